// File: rtl/mure_uop_packer.sv
// Retirement-to-trace micro-op packer with an output FIFO.
// Define MURE_EXTENDED_ITYPE_EN for 4-bit itypes with split jump classes.
module mure_uop_packer #(
    parameter int NRET        = 2,
    parameter int DEPTH       = 8,
    parameter int IRETIRE_LEN = 32,
    parameter int XLEN        = 32,
`ifdef MURE_EXTENDED_ITYPE_EN
    localparam int ITYPE_LEN  = 4,
`else
    localparam int ITYPE_LEN  = 3,
`endif
    localparam int UW = ITYPE_LEN + XLEN + IRETIRE_LEN + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NRET-1:0]            valid_i,
    input  logic [NRET-1:0][XLEN-1:0]  iaddr_i,
    input  logic [NRET-1:0][31:0]      inst_i,
    input  logic [NRET-1:0]            compressed_i,
    input  logic [NRET-1:0]            taken_i,
    input  logic [NRET-1:0]            exc_i,
    input  logic [NRET-1:0]            int_i,
    output logic [UW-1:0]              uop_o,
    output logic                       uop_valid_o,
    input  logic                       uop_ready_i,
    output logic                       overflow_o,
    input  logic                       clear_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NE = 2 * NRET;
    localparam int EW = $clog2(NE + 1);

    localparam logic [31:0] MRET = 32'h3020_0073;
    localparam logic [31:0] SRET = 32'h1020_0073;
    localparam logic [31:0] URET = 32'h0020_0073;

    function automatic logic [ITYPE_LEN-1:0] classify(
        input logic [31:0] in,
        input logic        c,
        input logic        tk,
        input logic        ex,
        input logic        it
    );
        logic eret, br, cb, jalr, cjr, cjalr;
`ifdef MURE_EXTENDED_ITYPE_EN
        logic jal, cj, cjal;
        logic [4:0] rd, rs1;
        rd   = in[11:7];
        rs1  = in[19:15];
        jal  = !c && in[6:0] == 7'b1101111;
        cj   = c && in[1:0] == 2'b01 && in[15:13] == 3'b101;
        cjal = c && in[1:0] == 2'b01 && in[15:13] == 3'b001;
`endif
        eret  = !c && (in == MRET || in == SRET || in == URET);
        br    = !c && in[6:0] == 7'b1100011;
        jalr  = !c && in[6:0] == 7'b1100111;
        cb    = c && in[1:0] == 2'b01 && in[15:14] == 2'b11;
        cjr   = c && in[1:0] == 2'b10 && in[15:12] == 4'b1000
                && in[6:2] == 5'd0 && in[11:7] != 5'd0;
        cjalr = c && in[1:0] == 2'b10 && in[15:12] == 4'b1001
                && in[6:2] == 5'd0 && in[11:7] != 5'd0;
        if (ex)                classify = ITYPE_LEN'(1);
        else if (it)           classify = ITYPE_LEN'(2);
        else if (eret)         classify = ITYPE_LEN'(3);
        else if (br || cb)     classify = tk ? ITYPE_LEN'(5) : ITYPE_LEN'(4);
`ifdef MURE_EXTENDED_ITYPE_EN
        else if ((jal && rd == 5'd1) || cjal)
            classify = ITYPE_LEN'(9);
        else if ((jalr && rd == 5'd1) || cjalr)
            classify = ITYPE_LEN'(8);
        else if ((jalr && rd == 5'd0 && rs1 == 5'd1) || (cjr && in[11:7] == 5'd1))
            classify = ITYPE_LEN'(13);
        else if ((jalr && rd == 5'd0) || cjr)
            classify = ITYPE_LEN'(10);
        else if ((jal && rd == 5'd0) || cj)
            classify = ITYPE_LEN'(11);
        else if (jalr)         classify = ITYPE_LEN'(14);
        else if (jal)          classify = ITYPE_LEN'(15);
`else
        else if (jalr || cjr || cjalr)
            classify = ITYPE_LEN'(6);
`endif
        else                   classify = '0;
    endfunction

    logic [UW-1:0]          mem_q [DEPTH];
    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]          occ_q, occ_d;
    logic [XLEN-1:0]        start_q, start_d;
    logic [IRETIRE_LEN-1:0] icnt_q, icnt_d;
    logic                   open_q, open_d;
    logic                   last_q, last_d;
    logic                   ovf_q, ovf_d;

    logic [UW-1:0]          ent [2**EW];
    logic [EW-1:0]          nemit;
    logic [IRETIRE_LEN-1:0] inc;
    logic [IRETIRE_LEN:0]   isum;
    logic [ITYPE_LEN-1:0]   ty;
    int                     free, npush;
    logic                   pop, drop;

    // Walk lanes oldest-first, carrying block state lane to lane.
    always_comb begin
        start_d = start_q;
        icnt_d  = icnt_q;
        open_d  = open_q;
        last_d  = last_q;
        nemit   = '0;
        inc     = '0;
        isum    = '0;
        ty      = '0;
        for (int s = 0; s < 2**EW; s++) ent[s] = '0;
        for (int k = 0; k < NRET; k++) begin
            if (valid_i[k]) begin
                inc  = compressed_i[k] ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
                isum = {1'b0, icnt_d} + {1'b0, inc};
                if (!open_d) begin
                    start_d = iaddr_i[k];
                    icnt_d  = '0;
                    open_d  = 1'b1;
                end else if (isum > {1'b0, {IRETIRE_LEN{1'b1}}}) begin
                    ent[nemit] = {ITYPE_LEN'(0), start_d, icnt_d, last_d};
                    nemit      = nemit + EW'(1);
                    start_d    = iaddr_i[k];
                    icnt_d     = '0;
                end
                icnt_d = icnt_d + inc;
                last_d = !compressed_i[k];
                ty = classify(inst_i[k], compressed_i[k], taken_i[k],
                              exc_i[k], int_i[k]);
                if (ty != '0) begin
                    ent[nemit] = {ty, start_d, icnt_d, !compressed_i[k]};
                    nemit      = nemit + EW'(1);
                    open_d     = 1'b0;
                end
            end
        end
    end

    // Space is judged before this cycle's pop; overflow keeps the oldest.
    always_comb begin
        free   = DEPTH - int'(occ_q);
        npush  = (int'(nemit) < free) ? int'(nemit) : free;
        drop   = int'(nemit) > free;
        pop    = (occ_q != '0) && uop_ready_i;
        wptr_d = wptr_q + PW'(npush);
        rptr_d = rptr_q + PW'(pop);
        occ_d  = occ_q + CW'(npush) - CW'(pop);
        ovf_d  = drop | (ovf_q & ~clear_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            start_q <= '0;
            icnt_q  <= '0;
            open_q  <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            start_q <= start_d;
            icnt_q  <= icnt_d;
            open_q  <= open_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NE; i++) begin
            if (i < npush) mem_q[wptr_q + PW'(i)] <= ent[i];
        end
    end

    assign uop_valid_o = occ_q != '0;
    assign uop_o       = uop_valid_o ? mem_q[rptr_q] : '0;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_mure_uop_packer.sv
// Directed bench for mure_uop_packer against an entry-queue reference model.
// Built with default itype width (MURE_EXTENDED_ITYPE_EN undefined).
module tb_mure_uop_packer;

    localparam int NRET = 2;
    localparam int DEPTH = 8;
    localparam int IRL = 4;
    localparam int XLEN = 32;
    localparam int UW = 3 + XLEN + IRL + 1;
    localparam int MAXC = 15;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic [NRET-1:0]           valid_i, compressed_i, taken_i, exc_i, int_i;
    logic [NRET-1:0][XLEN-1:0] iaddr_i;
    logic [NRET-1:0][31:0]     inst_i;
    logic [UW-1:0]             uop_o;
    logic                      uop_valid_o, uop_ready_i, overflow_o, clear_i;

    int total = 0;
    int bad = 0;

    int              mty [NRET];
    logic [UW-1:0]   mq [$];
    logic [XLEN-1:0] mstart;
    int              mcnt;
    bit              mopen, mls, movf;

    mure_uop_packer #(
        .NRET(NRET), .DEPTH(DEPTH), .IRETIRE_LEN(IRL), .XLEN(XLEN)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .iaddr_i(iaddr_i), .inst_i(inst_i), .compressed_i(compressed_i),
        .taken_i(taken_i), .exc_i(exc_i), .int_i(int_i),
        .uop_o(uop_o), .uop_valid_o(uop_valid_o), .uop_ready_i(uop_ready_i),
        .overflow_o(overflow_o), .clear_i(clear_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [UW-1:0] pk(int ty, logic [XLEN-1:0] a, int c, bit ls);
        return {3'(ty), a, 4'(c), ls};
    endfunction

    task automatic chk(input string nm, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mstart = '0;
        mcnt = 0;
        mopen = 0;
        mls = 0;
        movf = 0;
    endtask

    task automatic clr_lanes();
        valid_i = '0; compressed_i = '0; taken_i = '0;
        exc_i = '0; int_i = '0; iaddr_i = '0; inst_i = '0;
        for (int k = 0; k < NRET; k++) mty[k] = 0;
    endtask

    task automatic lane(input int k, input logic [31:0] a, input logic [31:0] in,
                        input bit c, input bit tk, input bit ex, input bit it, input int ty);
        valid_i[k] = 1'b1; iaddr_i[k] = a; inst_i[k] = in;
        compressed_i[k] = c; taken_i[k] = tk; exc_i[k] = ex; int_i[k] = it;
        mty[k] = ty;
    endtask

    // Expected entries follow from the block rules, using the hand-assigned itypes.
    task automatic model_step();
        logic [UW-1:0] em [$];
        int free, inc;
        bit pop;
        free = DEPTH - mq.size();
        pop = mq.size() != 0 && uop_ready_i;
        for (int k = 0; k < NRET; k++) begin
            if (valid_i[k]) begin
                inc = compressed_i[k] ? 1 : 2;
                if (!mopen) begin
                    mstart = iaddr_i[k]; mcnt = 0; mopen = 1;
                end else if (mcnt + inc > MAXC) begin
                    em.push_back(pk(0, mstart, mcnt, mls));
                    mstart = iaddr_i[k]; mcnt = 0;
                end
                mcnt += inc;
                mls = !compressed_i[k];
                if (mty[k] != 0) begin
                    em.push_back(pk(mty[k], mstart, mcnt, mls));
                    mopen = 0;
                end
            end
        end
        if (em.size() > free) movf = 1;
        else if (clear_i) movf = 0;
        foreach (em[i]) if (i < free) mq.push_back(em[i]);
        if (pop) void'(mq.pop_front());
    endtask

    task automatic check_all();
        chk("valid", UW'(uop_valid_o), UW'(mq.size() != 0));
        if (mq.size() != 0) chk("uop", uop_o, mq[0]);
        chk("overflow", UW'(overflow_o), UW'(movf));
    endtask

    task automatic go(input bit rdy, input bit clr);
        uop_ready_i = rdy;
        clear_i = clr;
        model_step();
        @(posedge clk_i);
        #1;
        check_all();
        clr_lanes();
        clear_i = 1'b0;
    endtask

    initial begin
        clr_lanes();
        uop_ready_i = 1'b1;
        clear_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", UW'(uop_valid_o), '0);
        chk("rst_uop", uop_o, '0);
        chk("rst_ovf", UW'(overflow_o), '0);
        rst_ni = 1'b1;

        // add + taken beq
        lane(0, 32'h100, 32'h003100B3, 0, 0, 0, 0, 0);
        lane(1, 32'h104, 32'h00000063, 0, 1, 0, 0, 5);
        go(1, 0);
        chk("tb_entry", uop_o, {3'd5, 32'h100, 4'd4, 1'b1});
        go(1, 0);

        // c.jr then mret: two entries in one cycle
        lane(0, 32'h200, 32'h00008082, 1, 0, 0, 0, 6);
        lane(1, 32'h202, 32'h30200073, 0, 0, 0, 0, 3);
        go(1, 0);
        chk("uij_entry", uop_o, {3'd6, 32'h200, 4'd1, 1'b0});
        go(1, 0);
        chk("eret_entry", uop_o, {3'd3, 32'h202, 4'd2, 1'b1});
        go(1, 0);

        // invalid lane 0 is skipped; taken c.beqz
        lane(1, 32'h300, 32'h0000C001, 1, 1, 0, 0, 5);
        go(1, 0);
        chk("cbeqz_entry", uop_o, {3'd5, 32'h300, 4'd1, 1'b0});
        lane(0, 32'h310, 32'h0000006F, 0, 0, 0, 0, 0);
        lane(1, 32'h314, 32'h00001063, 0, 0, 0, 0, 4);
        go(1, 0);
        chk("ntb_entry", uop_o, {3'd4, 32'h310, 4'd4, 1'b1});
        lane(0, 32'h320, 32'h003100B3, 0, 0, 1, 0, 1);
        lane(1, 32'h324, 32'h003100B3, 0, 0, 0, 1, 2);
        go(1, 0);
        lane(0, 32'h330, 32'h00008067, 0, 0, 0, 0, 6);
        lane(1, 32'h334, 32'h00009082, 1, 0, 0, 0, 6);
        go(1, 0);
        lane(0, 32'h340, 32'h00000001, 1, 0, 0, 0, 0);
        lane(1, 32'h342, 32'h10200073, 0, 0, 0, 0, 3);
        go(1, 0);
        repeat (6) go(1, 0);

        // iretire saturation with a 4-bit counter
        for (int i = 0; i < 4; i++) begin
            lane(0, 32'(8 * i), 32'h003100B3, 0, 0, 0, 0, 0);
            lane(1, 32'(8 * i + 4), 32'h003100B3, 0, 0, 0, 0, 0);
            go(1, 0);
        end
        chk("sat_entry", uop_o, {3'd0, 32'h0, 4'd14, 1'b1});
        lane(0, 32'h20, 32'h00000063, 0, 1, 0, 0, 5);
        go(1, 0);
        chk("sat_next", uop_o, {3'd5, 32'h1C, 4'd4, 1'b1});
        repeat (2) go(1, 0);

        // nine taken branches into a stalled 8-deep FIFO
        for (int i = 0; i < 4; i++) begin
            lane(0, 32'h600 + 32'(8 * i), 32'h00000063, 0, 1, 0, 0, 5);
            lane(1, 32'h604 + 32'(8 * i), 32'h00000063, 0, 1, 0, 0, 5);
            go(0, 0);
        end
        chk("full_noovf", UW'(overflow_o), '0);
        lane(0, 32'h620, 32'h00000063, 0, 1, 0, 0, 5);
        go(0, 0);
        chk("ovf_set", UW'(overflow_o), UW'(1));
        repeat (2) go(0, 0);
        lane(0, 32'h630, 32'h00000063, 0, 1, 0, 0, 5);
        go(0, 1);
        chk("ovf_clr_drop", UW'(overflow_o), UW'(1));
        go(0, 1);
        chk("ovf_clr", UW'(overflow_o), '0);
        chk("full_head", uop_o, {3'd5, 32'h600, 4'd2, 1'b1});
        repeat (9) go(1, 0);

        // reset with queued entries and an open block
        for (int i = 0; i < 3; i++) begin
            lane(0, 32'h700 + 32'(4 * i), 32'h00000063, 0, 1, 0, 0, 5);
            go(0, 0);
        end
        lane(0, 32'h710, 32'h003100B3, 0, 0, 0, 0, 0);
        go(0, 0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", UW'(uop_valid_o), '0);
        chk("mid_rst_uop", uop_o, '0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        lane(0, 32'h800, 32'h00000063, 0, 1, 0, 0, 5);
        go(1, 0);
        chk("post_rst_entry", uop_o, {3'd5, 32'h800, 4'd2, 1'b1});
        repeat (2) go(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
